// File: rtl/spi_byte_feeder.sv
// -----------------------------------------------------------------------------
// spi_byte_feeder
//   Byte FIFO feeding a downstream SPI byte sender through a req/sent
//   handshake. Each entry carries a data/command tag that follows the byte
//   out to the display D/C pin.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   wr_en     push request
//   wr_dat    byte to queue
//   wr_dc     data/command tag queued with the byte
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   count     number of queued entries (AW+1 bits)
//   overflow  sticky: a push was attempted while full (cleared by reset only)
//   spi_req   request to the sender, high only in REQ
//   spi_dat   byte in flight, stable from pop until the next pop
//   spi_dc    tag of the byte in flight
//   spi_snt   sender "byte sent" flag, held until spi_req falls
//   busy      FSM is not in IDLE
//
// FSM
//   state | meaning
//   IDLE  | waiting for a queued entry; pops it when spi_snt is low
//   LOAD  | one cycle of setup for spi_dat/spi_dc before the request
//   REQ   | spi_req high, waiting for spi_snt
//   REL   | spi_req low, waiting for spi_snt to clear
// -----------------------------------------------------------------------------
module spi_byte_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_dat,
  input  logic          wr_dc,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          spi_req,
  output logic [7:0]    spi_dat,
  output logic          spi_dc,
  input  logic          spi_snt,
  output logic          busy
);

  // Gray-coded so every legal transition flips one bit; spi_req and busy are
  // then decoded from the state flops without glitches.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_REQ  = 2'b11,
    ST_REL  = 2'b10
  } state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  state_t         state;
  state_t         state_nxt;
  logic [8:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           push;
  logic           pop;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;

  // full is the pre-edge value, so a push alongside a pop while full is
  // rejected even though the pop frees a slot.
  assign push = wr_en && !full;

  assign spi_req = (state == ST_REQ);
  assign busy    = (state != ST_IDLE);

  // Next state and pop decision. A pop needs spi_snt low so a stale "sent"
  // flag can never be taken as the acknowledge for a fresh byte.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !spi_snt) begin
          pop       = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_REQ;
      ST_REQ: begin
        if (spi_snt) state_nxt = ST_REL;
      end
      ST_REL: begin
        if (!spi_snt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Storage array carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_dc, wr_dat};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  // Hold registers for the byte in flight; loaded only on a pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_dat <= 8'h00;
      spi_dc  <= 1'b0;
    end else if (pop) begin
      {spi_dc, spi_dat} <= mem[rd_ptr];
    end
  end

endmodule
